// File: rtl/smem_output_collector_pkg.sv
// Shared definitions for the result-output collector: line geometry,
// header field positions and the arbiter/parser state encodings.
package smem_output_collector_pkg;

  // Width of one result line on the source and host sides
  localparam int LINE_W = 512;

  // Header field positions within the first line of each read group
  localparam int READ_NUM_LSB   = 0;
  localparam int READ_NUM_MSB   = 9;
  localparam int READ_NUM_WIDTH = READ_NUM_MSB - READ_NUM_LSB + 1;

  localparam int MEM_SIZE_LSB   = 64;
  localparam int MEM_SIZE_MSB   = 70;
  localparam int MEM_SIZE_WIDTH = MEM_SIZE_MSB - MEM_SIZE_LSB + 1;

  localparam int RET_LSB        = 128;
  localparam int RET_MSB        = 134;
  localparam int RET_WIDTH      = RET_MSB - RET_LSB + 1;

  // Width of the body-line countdown; mem-data entries pack two per line
  localparam int REMAIN_W = MEM_SIZE_WIDTH;

  // Arbiter: waiting for a requester, or holding permit on one source
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Parser: expecting a header line, or counting down mem-data lines
  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } parse_state_t;

  // Number of body lines that follow a header: two mem entries per line
  function automatic logic [REMAIN_W-1:0] body_lines(input logic [MEM_SIZE_WIDTH-1:0] mem_size);
    logic [MEM_SIZE_WIDTH:0] sum;
    sum = {1'b0, mem_size} + {{MEM_SIZE_WIDTH{1'b0}}, 1'b1};
    return sum[MEM_SIZE_WIDTH:1];
  endfunction

endpackage

// File: rtl/smem_output_collector_fifo.sv
// First-word-fall-through line buffer with an occupancy count. The head
// entry is always presented on head_data while the buffer is non-empty.
// Pushes into a full buffer and pops from an empty one are ignored; the
// parent decides whether that is an error.
module smem_line_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Line storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/smem_output_collector.sv
// Consumer end of the per-PE result output handshake. Grants permit to one
// requesting source at a time in round-robin order until it finishes, walks
// each source's stream as header / mem-data groups, buffers every consumed
// line and writes the lines to consecutive host line addresses.
module smem_output_collector
  import smem_output_collector_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 32,
  parameter int STALL_MARGIN = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [NUM_SRC-1:0]        src_request,
  output logic [NUM_SRC-1:0]        src_permit,
  input  logic [NUM_SRC*LINE_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_finish,
  output logic                      src_stall,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [LINE_W-1:0]         wr_data,
  output logic [15:0]               reads_rcvd,
  output logic [ADDR_W-1:0]         lines_written,
  output logic                      proto_err,
  output logic                      all_done
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Arbiter state
  arb_state_t          arb_state;
  arb_state_t          arb_next;
  logic [SEL_W-1:0]    sel;
  logic [SEL_W-1:0]    sel_next;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    rr_next;
  logic [NUM_SRC-1:0]  done_mask;
  logic [NUM_SRC-1:0]  done_next;
  logic [NUM_SRC-1:0]  pending;
  logic                cand_found;
  logic [SEL_W-1:0]    cand_idx;
  logic                granted;
  logic                new_grant;

  // Parser state
  parse_state_t        parse_state;
  parse_state_t        parse_next;
  logic [REMAIN_W-1:0] remaining;
  logic [REMAIN_W-1:0] rem_next;
  logic [REMAIN_W-1:0] hdr_remaining;
  logic                hdr_seen;
  logic                finish_mid_group;

  // Datapath
  logic                consume;
  logic [LINE_W-1:0]   line_in;
  logic                foreign_valid;
  logic                push_dropped;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    free_entries;
  logic [ADDR_W-1:0]   base_q;

  assign pending = src_request & ~done_mask;

  // Round-robin search: first pending source at or after the pointer
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!cand_found && pending[(int'(rr_ptr) + k) % NUM_SRC]) begin
        cand_found = 1'b1;
        cand_idx   = SEL_W'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  // Arbiter state register; start behaves like a reset for the whole collector
  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      arb_state <= IDLE;
      sel       <= '0;
      rr_ptr    <= '0;
      done_mask <= '0;
    end else begin
      arb_state <= arb_next;
      sel       <= sel_next;
      rr_ptr    <= rr_next;
      done_mask <= done_next;
    end
  end

  // Arbiter next state: grant a pending source, release it on its finish
  always_comb begin
    arb_next  = arb_state;
    sel_next  = sel;
    rr_next   = rr_ptr;
    done_next = done_mask;
    case (arb_state)
      IDLE: begin
        if (cand_found) begin
          sel_next = cand_idx;
          arb_next = GRANT;
        end
      end
      GRANT: begin
        if (src_finish[sel]) begin
          done_next[sel] = 1'b1;
          rr_next        = (sel == SEL_W'(NUM_SRC - 1)) ? '0 : sel + SEL_W'(1);
          arb_next       = IDLE;
        end
      end
      default: arb_next = IDLE;
    endcase
  end

  // Arbiter outputs: one-hot permit to the held source, grant strobes
  always_comb begin
    src_permit = '0;
    granted    = (arb_state == GRANT);
    new_grant  = (arb_state == IDLE) && cand_found;
    if (granted) src_permit[sel] = 1'b1;
  end

  assign consume       = granted && src_valid[sel];
  assign line_in       = src_data[int'(sel)*LINE_W +: LINE_W];
  assign foreign_valid = |(src_valid & ~src_permit);
  assign hdr_remaining = body_lines(line_in[MEM_SIZE_MSB:MEM_SIZE_LSB]);

  // Parser state register
  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      parse_state <= HDR;
      remaining   <= '0;
    end else begin
      parse_state <= parse_next;
      remaining   <= rem_next;
    end
  end

  // Parser next state: header loads the body countdown, body lines drain it
  always_comb begin
    parse_next = parse_state;
    rem_next   = remaining;
    if (new_grant) begin
      parse_next = HDR;
      rem_next   = '0;
    end else if (consume) begin
      case (parse_state)
        HDR: begin
          rem_next   = hdr_remaining;
          parse_next = (hdr_remaining == '0) ? HDR : BODY;
        end
        BODY: begin
          rem_next   = remaining - REMAIN_W'(1);
          parse_next = (remaining == REMAIN_W'(1)) ? HDR : BODY;
        end
        default: parse_next = HDR;
      endcase
    end
  end

  // Parser outputs: header strobe, and a source finishing inside a group
  always_comb begin
    hdr_seen         = consume && (parse_state == HDR);
    finish_mid_group = granted && src_finish[sel] && (parse_next == BODY);
  end

  assign pop          = wr_valid && wr_ready;
  assign push_dropped = consume && fifo_full;

  smem_line_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start),
    .push      (consume),
    .push_data (line_in),
    .pop       (pop),
    .head_data (wr_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign wr_valid     = !fifo_empty;
  assign wr_addr      = base_q + lines_written;
  assign free_entries = CNT_W'(FIFO_DEPTH) - fifo_count;

  // Counters, sticky error, registered stall and completion flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q        <= '0;
      reads_rcvd    <= '0;
      lines_written <= '0;
      proto_err     <= 1'b0;
      src_stall     <= 1'b0;
      all_done      <= 1'b0;
    end else if (start) begin
      base_q        <= base_addr;
      reads_rcvd    <= '0;
      lines_written <= '0;
      proto_err     <= 1'b0;
      src_stall     <= 1'b0;
      all_done      <= 1'b0;
    end else begin
      if (hdr_seen) reads_rcvd <= reads_rcvd + 16'd1;
      if (pop) lines_written <= lines_written + ADDR_W'(1);
      if (foreign_valid || finish_mid_group || push_dropped) proto_err <= 1'b1;
      src_stall <= (free_entries <= CNT_W'(STALL_MARGIN));
      all_done  <= (pending == '0) && (arb_state == IDLE) && fifo_empty;
    end
  end

endmodule

// File: tb/tb_smem_output_collector.sv
// Directed bench for the result-output collector: drives source streams
// against the permit/stall handshake, models the host write port and
// compares every accepted line against the expected address and data.
module tb_smem_output_collector;

  localparam int NUM_SRC      = 4;
  localparam int FIFO_DEPTH   = 16;
  localparam int ADDR_W       = 32;
  localparam int STALL_MARGIN = 4;
  localparam int LW           = 512;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic [NUM_SRC-1:0]    src_request;
  logic [NUM_SRC-1:0]    src_permit;
  logic [NUM_SRC*LW-1:0] src_data;
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_finish;
  logic                  src_stall;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [LW-1:0]         wr_data;
  logic [15:0]           reads_rcvd;
  logic [ADDR_W-1:0]     lines_written;
  logic                  proto_err;
  logic                  all_done;

  smem_output_collector #(
    .NUM_SRC      (NUM_SRC),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .ADDR_W       (ADDR_W),
    .STALL_MARGIN (STALL_MARGIN)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .src_request   (src_request),
    .src_permit    (src_permit),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_finish    (src_finish),
    .src_stall     (src_stall),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .reads_rcvd    (reads_rcvd),
    .lines_written (lines_written),
    .proto_err     (proto_err),
    .all_done      (all_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected and accepted host writes
  logic [LW-1:0]     exp_q[$];
  logic [LW-1:0]     tx_q[$];
  logic [ADDR_W-1:0] acc_addr[$];
  logic [LW-1:0]     acc_data[$];

  // Host-side write handshake and source-side stall bookkeeping
  bit auto_ready = 1'b1;
  int ready_hold = 0;
  int ready_block = 0;
  bit latency_check = 1'b0;
  bit stall_seen = 1'b0;
  int stall_occ = 0;
  int prev_occ = 0;
  int driven = 0;

  // Host model: a write is accepted where valid and ready are both high
  always @(negedge clk) begin
    if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
      acc_addr.push_back(wr_addr);
      acc_data.push_back(wr_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ready_hold > 0) ready_hold--;
    if (auto_ready) wr_ready = (ready_hold == 0);
    if (cyc > 20000) begin
      $display("[TB] FAIL watchdog cycles=%0d limit=20000", cyc);
      $fatal(1, "[TB] watchdog expired");
    end
  endtask

  function automatic logic [LW-1:0] mkHdr(input logic [9:0] read_num, input logic [6:0] mem_size,
                                          input logic [6:0] ret, input logic [15:0] tag);
    logic [LW-1:0] l;
    l = '0;
    l[9:0]     = read_num;
    l[70:64]   = mem_size;
    l[134:128] = ret;
    l[511:496] = tag;
    return l;
  endfunction

  function automatic logic [LW-1:0] mkData(input logic [15:0] tag, input logic [15:0] idx);
    logic [LW-1:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = {tag, idx} ^ 32'(w * 32'h01010101);
    return l;
  endfunction

  task automatic applyStimulus(input int s, input logic [LW-1:0] line);
    src_valid = '0;
    src_valid[s] = 1'b1;
    src_data[s*LW +: LW] = line;
    exp_q.push_back(line);
    driven++;
  endtask

  task automatic doStart(input logic [ADDR_W-1:0] base);
    src_request = '0;
    src_valid   = '0;
    src_finish  = '0;
    base_addr   = base;
    start       = 1'b1;
    tick();
    start = 1'b0;
    exp_q.delete();
    acc_addr.delete();
    acc_data.delete();
    driven     = 0;
    stall_seen = 1'b0;
    stall_occ  = 0;
    prev_occ   = 0;
  endtask

  task automatic waitPermit(input int s, input string tag);
    int n = 0;
    src_request[s] = 1'b1;
    while (src_permit[s] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, src_permit, 4'b1 << s);
  endtask

  // Honour stall at the source: only drive a line on cycles it is low
  task automatic sendStream(input int s, input string tag);
    int idx = 0;
    int guard = 0;
    bit lat_done = 1'b0;
    int occ;
    waitPermit(s, {tag, "_grant"});
    while (idx < tx_q.size() && guard < 2000) begin
      occ = driven - acc_addr.size();
      if (src_stall && !stall_seen) begin
        stall_seen = 1'b1;
        stall_occ  = prev_occ;
      end
      prev_occ = occ;
      if (!src_stall) begin
        applyStimulus(s, tx_q[idx]);
        if (idx == 0 && auto_ready && ready_block > 0) begin
          ready_hold = ready_block;
          wr_ready   = 1'b0;
        end
        idx++;
      end else begin
        src_valid = '0;
      end
      tick();
      guard++;
      if (latency_check && idx == 1 && !lat_done) begin
        lat_done = 1'b1;
        checkOutput({tag, "_lat_valid"}, wr_valid, 1'b1);
        checkOutput({tag, "_lat_addr"}, wr_addr, base_addr);
        checkOutput({tag, "_lat_data"}, wr_data, tx_q[0]);
        checkOutput({tag, "_busy_not_done"}, all_done, 1'b0);
      end
    end
    checkOutput({tag, "_all_sent"}, idx, tx_q.size());
    src_valid = '0;
  endtask

  task automatic finishSource(input int s, input string tag);
    int n = 0;
    src_valid = '0;
    src_finish[s] = 1'b1;
    while (src_permit[s] === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_release"}, src_permit, '0);
  endtask

  task automatic waitAllDone(input string tag);
    int n = 0;
    while (all_done !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    checkOutput({tag, "_all_done"}, all_done, 1'b1);
  endtask

  task automatic checkWrites(input string tag, input logic [ADDR_W-1:0] base);
    int n;
    checkOutput({tag, "_wr_count"}, acc_addr.size(), exp_q.size());
    n = (acc_addr.size() < exp_q.size()) ? acc_addr.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_line%0d", tag, i), {acc_addr[i], acc_data[i]},
                  {base + ADDR_W'(i), exp_q[i]});
  endtask

  initial begin
    int order[$];
    logic [NUM_SRC-1:0] fin;
    int phase[NUM_SRC];
    int regrant;

    reset_n     = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    src_request = '0;
    src_valid   = '0;
    src_finish  = '0;
    src_data    = '0;
    wr_ready    = 1'b1;
    tick();
    tick();

    // Reset state
    checkOutput("rst_permit", src_permit, '0);
    checkOutput("rst_stall", src_stall, 1'b0);
    checkOutput("rst_wr_valid", wr_valid, 1'b0);
    checkOutput("rst_reads", reads_rcvd, '0);
    checkOutput("rst_lines", lines_written, '0);
    checkOutput("rst_proto", proto_err, 1'b0);
    checkOutput("rst_done", all_done, 1'b0);
    reset_n = 1'b1;

    // One source, two reads: mem_size 3 -> 2 body lines, mem_size 2 -> 1 body line
    doStart(32'h100);
    tx_q.delete();
    tx_q.push_back(mkHdr(10'd1, 7'd3, 7'd5, 16'h0001));
    tx_q.push_back(mkData(16'h0001, 16'd0));
    tx_q.push_back(mkData(16'h0001, 16'd1));
    tx_q.push_back(mkHdr(10'd2, 7'd2, 7'd6, 16'h0002));
    tx_q.push_back(mkData(16'h0001, 16'd2));
    latency_check = 1'b1;
    sendStream(0, "t1");
    latency_check = 1'b0;
    finishSource(0, "t1");
    waitAllDone("t1");
    checkWrites("t1", 32'h100);
    checkOutput("t1_reads", reads_rcvd, 16'd2);
    checkOutput("t1_lines", lines_written, 32'd5);
    checkOutput("t1_proto", proto_err, 1'b0);

    // Four requesters, one empty read each: round-robin order, no re-grant
    doStart(32'h200);
    src_request = '1;
    fin = '0;
    regrant = 0;
    for (int i = 0; i < NUM_SRC; i++) phase[i] = 0;
    for (int c = 0; c < 200 && fin != '1; c++) begin
      if ((src_permit & fin) != '0) regrant++;
      src_valid = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_permit[i]) begin
          if (phase[i] == 0) begin
            order.push_back(i);
            applyStimulus(i, mkHdr(10'(i + 1), 7'd0, 7'(i), 16'(32'h20 + i)));
            phase[i] = 1;
          end else if (phase[i] == 1) begin
            src_finish[i] = 1'b1;
            fin[i] = 1'b1;
            phase[i] = 2;
          end
        end
      end
      tick();
    end
    src_valid = '0;
    checkOutput("t2_all_finished", fin, 4'hF);
    checkOutput("t2_order_len", order.size(), 4);
    for (int i = 0; i < order.size(); i++)
      checkOutput($sformatf("t2_order%0d", i), order[i], i);
    waitAllDone("t2");
    checkOutput("t2_regrant", regrant, 0);
    checkOutput("t2_permit_idle", src_permit, '0);
    checkOutput("t2_proto", proto_err, 1'b0);
    checkOutput("t2_reads", reads_rcvd, 16'd4);
    checkOutput("t2_lines", lines_written, 32'd4);
    checkWrites("t2", 32'h200);

    // 40-line stream with the host stalled for 20 cycles
    doStart(32'h300);
    tx_q.delete();
    tx_q.push_back(mkHdr(10'd7, 7'd78, 7'd1, 16'h0300));
    for (int i = 0; i < 39; i++) tx_q.push_back(mkData(16'h0003, 16'(i)));
    ready_block = 20;
    sendStream(1, "t3");
    ready_block = 0;
    finishSource(1, "t3");
    waitAllDone("t3");
    checkOutput("t3_stall_seen", stall_seen, 1'b1);
    checkOutput("t3_stall_occ", stall_occ, 12);
    checkOutput("t3_proto", proto_err, 1'b0);
    checkOutput("t3_lines", lines_written, 32'd40);
    checkWrites("t3", 32'h300);

    // Hold the buffer at full-minus-one with push and pop together
    doStart(32'h400);
    auto_ready = 1'b0;
    wr_ready   = 1'b0;
    tx_q.delete();
    tx_q.push_back(mkHdr(10'd9, 7'd50, 7'd2, 16'h0400));
    for (int i = 0; i < 25; i++) tx_q.push_back(mkData(16'h0004, 16'(i)));
    waitPermit(2, "t4_grant");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(2, tx_q[i]);
      tick();
    end
    checkOutput("t4_fill_count", dut.u_fifo.count, 15);
    checkOutput("t4_fill_stall", src_stall, 1'b1);
    wr_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      applyStimulus(2, tx_q[15 + j]);
      tick();
      checkOutput($sformatf("t4_occ%0d", j), dut.u_fifo.count, 15);
    end
    applyStimulus(2, tx_q[25]);
    tick();
    src_valid  = '0;
    auto_ready = 1'b1;
    finishSource(2, "t4");
    waitAllDone("t4");
    checkOutput("t4_proto", proto_err, 1'b0);
    checkWrites("t4", 32'h400);

    // Valid from a source that holds no permit
    doStart(32'h500);
    src_valid = '0;
    src_valid[3] = 1'b1;
    src_data[3*LW +: LW] = mkData(16'h0005, 16'd0);
    tick();
    src_valid = '0;
    tick();
    tick();
    checkOutput("t5_proto", proto_err, 1'b1);
    checkOutput("t5_wr_valid", wr_valid, 1'b0);
    checkOutput("t5_lines", lines_written, '0);
    checkOutput("t5_no_write", acc_addr.size(), 0);

    // Reset with five lines buffered, then restart at a new base
    doStart(32'h600);
    auto_ready = 1'b0;
    wr_ready   = 1'b0;
    tx_q.delete();
    tx_q.push_back(mkHdr(10'd3, 7'd8, 7'd4, 16'h0600));
    for (int i = 0; i < 4; i++) tx_q.push_back(mkData(16'h0006, 16'(i)));
    waitPermit(0, "t6_grant");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, tx_q[i]);
      tick();
    end
    src_valid = '0;
    checkOutput("t6_buffered", wr_valid, 1'b1);
    checkOutput("t6_reads_pre", reads_rcvd, 16'd1);
    reset_n = 1'b0;
    tick();
    checkOutput("t6_rst_permit", src_permit, '0);
    checkOutput("t6_rst_wr_valid", wr_valid, 1'b0);
    checkOutput("t6_rst_reads", reads_rcvd, '0);
    checkOutput("t6_rst_lines", lines_written, '0);
    checkOutput("t6_rst_stall", src_stall, 1'b0);
    reset_n    = 1'b1;
    auto_ready = 1'b1;
    wr_ready   = 1'b1;
    doStart(32'h700);
    tx_q.delete();
    tx_q.push_back(mkHdr(10'd4, 7'd2, 7'd3, 16'h0700));
    tx_q.push_back(mkData(16'h0007, 16'd0));
    sendStream(1, "t6b");
    finishSource(1, "t6b");
    waitAllDone("t6b");
    checkWrites("t6b", 32'h700);
    checkOutput("t6b_reads", reads_rcvd, 16'd1);
    checkOutput("t6b_proto", proto_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
